data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable RISC-V data memory with sized, signed/unsigned loads and stores.
// Define DATA_MEM_SPLIT_EN to run word-crossing accesses as two beats; otherwise they return rsp_err.
module data_mem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int WORDS = 1 << IDX_W;

`ifdef DATA_MEM_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;
  state_t state_reg, state_next;

  logic              we_reg;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [XLEN-1:0]   rd_word;
  logic [XLEN-1:0]   lo_word_reg;

  logic [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  acc_idx;
  logic [3:0]        size_bytes;
  logic [NB-1:0]     size_mask;
  logic              crosses;
  logic              illegal;
  logic              err;
  logic              split;
  logic              beat_hi;
  logic              acc_en;
  logic              wr_active;

  assign offset     = addr_reg[OFF_W-1:0];
  assign idx        = addr_reg[ADDR_W-1:OFF_W];
  assign size_bytes = 4'd1 << funct3_reg[1:0];
  assign crosses    = ({1'b0, size_bytes} + 5'(offset)) > 5'(NB);

  always_comb begin
    illegal = 1'b0;
    if (we_reg)
      illegal = funct3_reg[2];
    else
      illegal = (funct3_reg == 3'b111);
    if (XLEN == 32 && (funct3_reg == 3'b011 || funct3_reg == 3'b110))
      illegal = 1'b1;
  end

  assign err   = illegal || (crosses && !SPLIT);
  assign split = crosses && !err;

  always_comb begin
    size_mask = '0;
    for (int b = 0; b < NB; b++)
      size_mask[b] = (b < int'(size_bytes));
  end

  // The access is laid out over a two-word window; BEAT1 uses the low word, BEAT2 the high word.
  logic [2*XLEN-1:0] wdata_win;
  logic [2*NB-1:0]   be_win;
  logic [XLEN-1:0]   wr_word;
  logic [NB-1:0]     wr_en;

  assign wdata_win = {{XLEN{1'b0}}, wdata_reg} << {offset, 3'b000};
  assign be_win    = {{NB{1'b0}}, size_mask} << offset;
  assign beat_hi   = (state_reg == BEAT2);
  assign acc_en    = (state_reg == BEAT1) || (state_reg == BEAT2);
  assign acc_idx   = beat_hi ? idx + IDX_W'(1) : idx;
  // Gating with rst lets a reset in BEAT2 abort the second half of a split store.
  assign wr_active = acc_en && we_reg && !err && !rst;
  assign wr_word   = beat_hi ? wdata_win[XLEN +: XLEN] : wdata_win[0 +: XLEN];
  assign wr_en     = wr_active ? (beat_hi ? be_win[NB +: NB] : be_win[0 +: NB]) : '0;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [WORDS];
      logic [7:0] rd_byte;
      always_ff @(posedge clk) begin
        if (wr_en[gi])
          mem[acc_idx] <= wr_word[gi*8 +: 8];
        if (acc_en)
          rd_byte <= mem[acc_idx];
      end
      assign rd_word[gi*8 +: 8] = rd_byte;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
    if (!rst && state_reg == IDLE && req_valid) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      addr_reg   <= req_addr;
      wdata_reg  <= req_wdata;
    end
    if (state_reg == BEAT2)
      lo_word_reg <= rd_word;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = BEAT1;
      BEAT1:   state_next = split ? BEAT2 : RESP;
      BEAT2:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [2*XLEN-1:0] rd_win;
  logic [XLEN-1:0]   rd_shift;
  logic [XLEN-1:0]   ext_mask;
  logic              sign_bit;
  logic [XLEN-1:0]   load_val;

  assign rd_win   = split ? {rd_word, lo_word_reg} : {{XLEN{1'b0}}, rd_word};
  assign rd_shift = XLEN'(rd_win >> {offset, 3'b000});

  always_comb begin
    ext_mask = '1;
    sign_bit = 1'b0;
    case (funct3_reg[1:0])
      2'b00: begin ext_mask = XLEN'(64'hFF);        sign_bit = rd_shift[7];  end
      2'b01: begin ext_mask = XLEN'(64'hFFFF);      sign_bit = rd_shift[15]; end
      2'b10: begin ext_mask = XLEN'(64'hFFFF_FFFF); sign_bit = rd_shift[31]; end
      default: begin ext_mask = '1; sign_bit = 1'b0; end
    endcase
    load_val = rd_shift & ext_mask;
    if (!funct3_reg[2] && sign_bit)
      load_val = load_val | ~ext_mask;
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = rsp_valid && err;
  assign rsp_rdata = (rsp_valid && !we_reg && !err) ? load_val : '0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl (ADDR_W=10, XLEN=64); expectations follow DATA_MEM_SPLIT_EN.
module tb_data_mem_ctrl;
`ifdef DATA_MEM_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  data_mem_ctrl #(.ADDR_W(10), .XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   next_id = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: pops one expectation per response strobe; outputs must be quiet otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp got rsp_valid=1 want no response");
        end else begin
          exp_t e;
          int   lat;
          e   = sb_q.pop_front();
          lat = cycle + 1 - e.acc;
          checks++;
          if (rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL rsp%0d_rdata got %h want %h", e.id, rsp_rdata, e.rdata);
          end
          checks++;
          if (rsp_err !== e.err) begin
            errors++;
            $display("FAIL rsp%0d_err got %0b want %0b", e.id, rsp_err, e.err);
          end
          checks++;
          if (lat != e.lat) begin
            errors++;
            $display("FAIL rsp%0d_latency got %0d want %0d", e.id, lat, e.lat);
          end
          $display("rsp%0d rdata=%h err=%0b latency=%0d", e.id, rsp_rdata, rsp_err, lat);
        end
      end else begin
        checks++;
        if (rsp_rdata !== 64'h0 || rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs got rdata=%h err=%0b want 0/0", rsp_rdata, rsp_err);
        end
      end
    end
  end

  task automatic wait_ready();
    int waited = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout got %0b want 1", req_ready);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [9:0] a,
                       input logic [63:0] wd, input logic [63:0] er, input logic ee,
                       input int lat);
    wait_ready();
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    sb_q.push_back('{rdata: er, err: ee, lat: lat, acc: cycle + 1, id: next_id});
    $display("req%0d we=%0b funct3=%03b addr=%h wdata=%h", next_id, we, f3, a, wd);
    next_id++;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] x_lat3;
    int          waited;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ready=%0b valid=%0b rdata=%h err=%0b want 1/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    mon_en = 1'b1;

    issue(1, 3'b011, 10'h000, 64'h0706050403020100, 64'h0, 0, 2);
    issue(1, 3'b011, 10'h008, 64'h0F0E0D0C0B0A0908, 64'h0, 0, 2);
    issue(1, 3'b011, 10'h010, 64'h8877665544332211, 64'h0, 0, 2);
    issue(0, 3'b011, 10'h010, 64'h0, 64'h8877665544332211, 0, 2);
    issue(1, 3'b000, 10'h003, 64'h123456789ABCDE80, 64'h0, 0, 2);
    issue(0, 3'b000, 10'h003, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 2);
    issue(0, 3'b100, 10'h003, 64'h0, 64'h0000000000000080, 0, 2);
    issue(0, 3'b011, 10'h000, 64'h0, 64'h0706050480020100, 0, 2);

    // Word-crossing sw/lwu at 0x6: split in two beats or rejected outright.
    x_lat3 = 64'h0;
    issue(1, 3'b010, 10'h006, 64'hCAFEBABEDEADBEEF, 64'h0, !SPLIT, SPLIT ? 3 : 2);
    issue(0, 3'b110, 10'h006, 64'h0, SPLIT ? 64'h00000000DEADBEEF : x_lat3, !SPLIT, SPLIT ? 3 : 2);
    issue(0, 3'b011, 10'h000, 64'h0, SPLIT ? 64'hBEEF050480020100 : 64'h0706050480020100, 0, 2);
    issue(0, 3'b011, 10'h008, 64'h0, SPLIT ? 64'h0F0E0D0C0B0ADEAD : 64'h0F0E0D0C0B0A0908, 0, 2);

    issue(0, 3'b001, 10'h011, 64'h0, 64'h0000000000003322, 0, 2);
    issue(0, 3'b010, 10'h014, 64'h0, 64'hFFFFFFFF88776655, 0, 2);
    issue(0, 3'b110, 10'h014, 64'h0, 64'h0000000088776655, 0, 2);
    issue(0, 3'b001, 10'h016, 64'h0, 64'hFFFFFFFFFFFF8877, 0, 2);
    issue(0, 3'b101, 10'h016, 64'h0, 64'h0000000000008877, 0, 2);
    issue(0, 3'b010, 10'h012, 64'h0, 64'h0000000066554433, 0, 2);

    issue(0, 3'b111, 10'h000, 64'h0, 64'h0, 1, 2);
    issue(1, 3'b100, 10'h010, 64'h00000000000000FF, 64'h0, 1, 2);
    issue(0, 3'b100, 10'h010, 64'h0, 64'h0000000000000011, 0, 2);

    issue(1, 3'b001, 10'h00E, 64'h0000000055551234, 64'h0, 0, 2);
    issue(0, 3'b011, 10'h008, 64'h0, SPLIT ? 64'h12340D0C0B0ADEAD : 64'h12340D0C0B0A0908, 0, 2);
    issue(0, 3'b101, 10'h00E, 64'h0, 64'h0000000000001234, 0, 2);
    issue(0, 3'b101, 10'h007, 64'h0, SPLIT ? 64'h000000000000ADBE : x_lat3, !SPLIT, SPLIT ? 3 : 2);

    // Reset mid-transaction: no response, ready again right after the reset edge.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011;
`ifdef DATA_MEM_SPLIT_EN
    req_addr = 10'h004;
`else
    req_addr = 10'h020;
`endif
    req_wdata = 64'h1716151413121110;
    $display("req_abort we=1 funct3=011 addr=%h wdata=%h", req_addr, req_wdata);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef DATA_MEM_SPLIT_EN
    @(negedge clk);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got ready=%0b valid=%0b want 1/0", req_ready, rsp_valid);
    end
    repeat (4) @(negedge clk);

    issue(0, 3'b011, 10'h000, 64'h0, SPLIT ? 64'h1312111080020100 : 64'h0706050480020100, 0, 2);
    issue(0, 3'b011, 10'h008, 64'h0, SPLIT ? 64'h12340D0C0B0ADEAD : 64'h12340D0C0B0A0908, 0, 2);

`ifdef DATA_MEM_SPLIT_EN
    issue(1, 3'b001, 10'h3FF, 64'h000000000000A55A, 64'h0, 0, 3);
    issue(0, 3'b100, 10'h3FF, 64'h0, 64'h000000000000005A, 0, 2);
    issue(0, 3'b100, 10'h000, 64'h0, 64'h00000000000000A5, 0, 2);
`else
    issue(1, 3'b001, 10'h3FF, 64'h000000000000A55A, 64'h0, 1, 2);
    issue(0, 3'b100, 10'h000, 64'h0, 64'h0000000000000000, 0, 2);
`endif

    waited = 0;
    while (sb_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL missing_rsp got %0d outstanding want 0", sb_q.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
